fabric_boot_manager: RTL and testbench

Parametrised bitstream-source manager sitting between the configuration sources (SPI flash controller on source 0, passive receivers on sources 1..NUM_SOURCES-1) and `fabric_config`. It synchronises reset and mode, routes the selected source's bitstream words to the config engine, and sequences startup boot and warmboot. Beyond the current fixed two-way mux, it adds N sources, a load watchdog, single fallback retry, a one-deep warmboot queue, error reporting and a boot counter.

---
 rtl/fabric_boot_manager.sv | 193 +++++++++++++++++++
 tb/tb_fabric_boot_manager.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_boot_manager.sv
// Bitstream-source manager: synchronises reset/mode, routes the selected source to the
// config engine and sequences startup boot, warmboot, fallback retry and load watchdog.
//   state   | meaning
//   BOOT    | first cycle after reset release, picks flash boot or passive
//   IDLE    | configured, waiting for warmboot or mode change
//   START   | start pulse issued to flash controller this cycle
//   LOAD    | flash/config engine loading, watchdog running
//   PASSIVE | external source drives the config engine, no starts
//   ERROR   | load failed after fallback retry
module fabric_boot_manager #(
  parameter int NUM_SOURCES    = 2,
  parameter int DATA_W         = 32,
  parameter int SLOT_W         = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FALLBACK_SLOT  = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8,
  localparam int SRC_W         = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SRC_W-1:0]              mode_i,
  input  logic [NUM_SOURCES*DATA_W-1:0] src_data_i,
  input  logic [NUM_SOURCES-1:0]        src_valid_i,
  output logic                          ctrl_start_o,
  output logic [SLOT_W-1:0]             ctrl_slot_o,
  input  logic                          ctrl_busy_i,
  input  logic                          cfg_busy_i,
  input  logic                          cfg_configured_i,
  input  logic                          warmboot_req_i,
  input  logic [SLOT_W-1:0]             warmboot_slot_i,
  output logic                          rst_n_sync_o,
  output logic [DATA_W-1:0]             bs_data_o,
  output logic                          bs_valid_o,
  output logic [SRC_W-1:0]              src_sel_o,
  output logic                          busy_o,
  output logic                          error_o,
  output logic [CNT_W-1:0]              boot_count_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_START, S_LOAD, S_PASSIVE, S_ERROR
  } state_t;

  state_t                             state, state_nxt;
  logic [SYNC_STAGES-1:0]             rst_sync;
  logic [SYNC_STAGES-1:0][SRC_W-1:0]  mode_sync;
  logic [SRC_W-1:0]                   mode_s, mode_v;
  logic                               wb_q, wb_edge;
  logic                               q_valid;
  logic [SLOT_W-1:0]                  q_slot;
  logic                               seen, retried;
  logic [TMR_W-1:0]                   tmr;
  logic                               tmr_tc, load_done;
  logic                               launch;
  logic [SLOT_W-1:0]                  launch_slot;
  logic [DATA_W-1:0]                  sel_data;
  logic                               sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_n_sync_o = rst_sync[SYNC_STAGES-1];

  // Mode chain runs off the raw reset so mode_s is settled by the time BOOT samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_sync <= '0;
    else        mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_i};
  end
  assign mode_s = mode_sync[SYNC_STAGES-1];
  assign mode_v = (int'(mode_s) < NUM_SOURCES) ? mode_s : '0;

  assign wb_edge   = warmboot_req_i & ~wb_q;
  assign tmr_tc    = (tmr == '0);
  assign load_done = seen & ~ctrl_busy_i & ~cfg_busy_i;
  assign busy_o    = !(state inside {S_IDLE, S_PASSIVE, S_ERROR}) || cfg_busy_i;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (src_sel_o == SRC_W'(k)) begin
        sel_data  = src_data_i[k*DATA_W +: DATA_W];
        sel_valid = src_valid_i[k];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    launch_slot = '0;
    case (state)
      S_BOOT:
        if (mode_v == '0) launch = 1'b1;
        else              state_nxt = S_PASSIVE;
      S_IDLE:
        if (mode_v != '0) state_nxt = S_PASSIVE;
        else if (wb_edge) begin
          launch      = 1'b1;
          launch_slot = warmboot_slot_i;
        end else if (q_valid) begin
          launch      = 1'b1;
          launch_slot = q_slot;
        end
      S_START: state_nxt = S_LOAD;
      S_LOAD:
        if (load_done && cfg_configured_i) state_nxt = S_IDLE;
        else if (load_done || tmr_tc) begin
          if (!retried) begin
            launch      = 1'b1;
            launch_slot = SLOT_W'(FALLBACK_SLOT);
          end else begin
            state_nxt = S_ERROR;
          end
        end
      S_PASSIVE:
        if (mode_v == '0 && !cfg_busy_i) state_nxt = S_IDLE;
      S_ERROR:
        if (wb_edge) begin
          launch      = 1'b1;
          launch_slot = warmboot_slot_i;
        end else if (mode_v != '0) begin
          state_nxt = S_PASSIVE;
        end
      default: state_nxt = S_IDLE;
    endcase
    if (launch) state_nxt = S_START;
  end

  always_ff @(posedge clk or negedge rst_n_sync_o) begin
    if (!rst_n_sync_o) begin
      state        <= S_BOOT;
      ctrl_start_o <= 1'b0;
      ctrl_slot_o  <= '0;
      boot_count_o <= '0;
      error_o      <= 1'b0;
      src_sel_o    <= '0;
      bs_data_o    <= '0;
      bs_valid_o   <= 1'b0;
      wb_q         <= 1'b0;
      q_valid      <= 1'b0;
      q_slot       <= '0;
      seen         <= 1'b0;
      retried      <= 1'b0;
      tmr          <= '0;
    end else begin
      state        <= state_nxt;
      ctrl_start_o <= launch;
      wb_q         <= warmboot_req_i;
      bs_data_o    <= sel_data;
      bs_valid_o   <= sel_valid;
      if (launch) begin
        ctrl_slot_o <= launch_slot;
        if (boot_count_o != '1) boot_count_o <= boot_count_o + CNT_W'(1);
      end
      if (state inside {S_IDLE, S_PASSIVE, S_ERROR} && !cfg_busy_i) src_sel_o <= mode_v;
      // Queue holds the most recent edge seen while a load is in flight.
      if (state inside {S_START, S_LOAD} && wb_edge) begin
        q_valid <= 1'b1;
        q_slot  <= warmboot_slot_i;
      end
      case (state)
        S_IDLE:
          if (launch) q_valid <= 1'b0;
        S_START: begin
          seen <= 1'b0;
          tmr  <= TMR_W'(TIMEOUT_CYCLES - 1);
        end
        S_LOAD: begin
          if (ctrl_busy_i) seen <= 1'b1;
          if (!tmr_tc) tmr <= tmr - TMR_W'(1);
          if (state_nxt == S_IDLE)  retried <= 1'b0;
          if (launch)               retried <= 1'b1;
          if (state_nxt == S_ERROR) error_o <= 1'b1;
        end
        S_ERROR:
          if (launch) begin
            retried <= 1'b0;
            error_o <= 1'b0;
            q_valid <= 1'b0;
          end else if (state_nxt == S_PASSIVE) begin
            error_o <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_boot_manager.sv
// Directed bench for fabric_boot_manager: startup, warmboot queue, fallback, watchdog,
// passive routing and reset during a load.
module tb_fabric_boot_manager;
  localparam int NS    = 2;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int TMO   = 128;
  localparam int CW    = 8;
  localparam int SRC_W = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SRC_W-1:0]  mode_i;
  logic [NS*DW-1:0]  src_data_i;
  logic [NS-1:0]     src_valid_i;
  logic              ctrl_start_o;
  logic [SW-1:0]     ctrl_slot_o;
  logic              ctrl_busy_i;
  logic              cfg_busy_i;
  logic              cfg_configured_i;
  logic              warmboot_req_i;
  logic [SW-1:0]     warmboot_slot_i;
  logic              rst_n_sync_o;
  logic [DW-1:0]     bs_data_o;
  logic              bs_valid_o;
  logic [SRC_W-1:0]  src_sel_o;
  logic              busy_o;
  logic              error_o;
  logic [CW-1:0]     boot_count_o;

  int n_chk = 0;
  int n_err = 0;
  int n_starts = 0;

  fabric_boot_manager #(
    .NUM_SOURCES(NS), .DATA_W(DW), .SLOT_W(SW), .TIMEOUT_CYCLES(TMO),
    .FALLBACK_SLOT(0), .SYNC_STAGES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i),
    .ctrl_start_o(ctrl_start_o), .ctrl_slot_o(ctrl_slot_o),
    .ctrl_busy_i(ctrl_busy_i), .cfg_busy_i(cfg_busy_i),
    .cfg_configured_i(cfg_configured_i),
    .warmboot_req_i(warmboot_req_i), .warmboot_slot_i(warmboot_slot_i),
    .rst_n_sync_o(rst_n_sync_o), .bs_data_o(bs_data_o), .bs_valid_o(bs_valid_o),
    .src_sel_o(src_sel_o), .busy_o(busy_o), .error_o(error_o),
    .boot_count_o(boot_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ctrl_start_o === 1'b1) n_starts <= n_starts + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    int early;
    rst_n = 1'b0; mode_i = '0; src_data_i = '0; src_valid_i = '0;
    ctrl_busy_i = 1'b0; cfg_busy_i = 1'b0; cfg_configured_i = 1'b0;
    warmboot_req_i = 1'b0; warmboot_slot_i = '0;
    tick(3);
    check("rst_start", ctrl_start_o, 0);
    check("rst_slot", ctrl_slot_o, 0);
    check("rst_bs_data", bs_data_o, 0);
    check("rst_bs_valid", bs_valid_o, 0);
    check("rst_src_sel", src_sel_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_error", error_o, 0);
    check("rst_count", boot_count_o, 0);
    check("rst_sync", rst_n_sync_o, 0);

    // Startup in flash mode, two warmboot edges queued during the load
    rst_n = 1'b1;
    tick(1); check("sync_stage1", rst_n_sync_o, 0);
    tick(1); check("sync_stage2", rst_n_sync_o, 1);
    check("boot_no_start", ctrl_start_o, 0);
    tick(1); check("boot_start", ctrl_start_o, 1);
    check("boot_slot", ctrl_slot_o, 0);
    check("boot_count1", boot_count_o, 1);
    ctrl_busy_i = 1'b1;
    tick(1); check("start_one_cycle", ctrl_start_o, 0);
    for (int i = 1; i < 100; i++) begin
      warmboot_req_i = (i == 10 || i == 20);
      if (i == 10) warmboot_slot_i = 4'd3;
      if (i == 20) warmboot_slot_i = 4'd7;
      tick(1);
    end
    warmboot_req_i = 1'b0;
    check("load_busy", busy_o, 1);
    ctrl_busy_i = 1'b0; cfg_configured_i = 1'b1;
    tick(1); check("idle_busy", busy_o, 0);
    check("idle_error", error_o, 0);
    check("idle_count", boot_count_o, 1);
    tick(1); check("queue_start", ctrl_start_o, 1);
    check("queue_slot", ctrl_slot_o, 7);
    check("queue_count", boot_count_o, 2);
    ctrl_busy_i = 1'b1;
    tick(5); ctrl_busy_i = 1'b0;
    tick(4); check("queue_single", n_starts, 2);
    check("queue_idle_busy", busy_o, 0);

    // Warmboot in IDLE, failing load, failing fallback, recovery by warmboot
    warmboot_req_i = 1'b1; warmboot_slot_i = 4'd5;
    tick(1); check("wb_start", ctrl_start_o, 1);
    check("wb_slot", ctrl_slot_o, 5);
    check("wb_count", boot_count_o, 3);
    warmboot_req_i = 1'b0; ctrl_busy_i = 1'b1; cfg_configured_i = 1'b0;
    tick(5); ctrl_busy_i = 1'b0;
    tick(1); check("fb_start", ctrl_start_o, 1);
    check("fb_slot", ctrl_slot_o, 0);
    check("fb_count", boot_count_o, 4);
    ctrl_busy_i = 1'b1;
    tick(5); ctrl_busy_i = 1'b0;
    tick(1); check("err_set", error_o, 1);
    check("err_busy", busy_o, 0);
    check("err_no_start", ctrl_start_o, 0);
    tick(2); check("err_hold", error_o, 1);
    warmboot_req_i = 1'b1; warmboot_slot_i = 4'd2;
    tick(1); check("err_wb_start", ctrl_start_o, 1);
    check("err_wb_slot", ctrl_slot_o, 2);
    check("err_cleared", error_o, 0);
    check("err_wb_count", boot_count_o, 5);
    warmboot_req_i = 1'b0; ctrl_busy_i = 1'b1; cfg_configured_i = 1'b1;
    tick(3); ctrl_busy_i = 1'b0;
    tick(2); check("recover_idle", busy_o, 0);

    // Watchdog: busy stuck high, retry after TMO load cycles, error after another TMO
    warmboot_req_i = 1'b1; warmboot_slot_i = 4'd9;
    tick(1); check("wd_start", ctrl_start_o, 1);
    check("wd_slot", ctrl_slot_o, 9);
    warmboot_req_i = 1'b0; ctrl_busy_i = 1'b1;
    early = 0;
    for (int j = 1; j <= TMO; j++) begin
      tick(1);
      if (ctrl_start_o) early++;
    end
    check("wd_no_early_retry", early, 0);
    tick(1); check("wd_retry_start", ctrl_start_o, 1);
    check("wd_retry_slot", ctrl_slot_o, 0);
    check("wd_retry_count", boot_count_o, 7);
    early = 0;
    for (int j = 1; j <= TMO; j++) begin
      tick(1);
      if (error_o) early++;
    end
    check("wd_no_early_error", early, 0);
    tick(1); check("wd_error", error_o, 1);
    check("wd_no_start", ctrl_start_o, 0);
    ctrl_busy_i = 1'b0;

    // Passive mode from ERROR: source 1 routed, source 0 ignored, edges dropped
    mode_i = 1'b1;
    tick(4); check("pas_error_clear", error_o, 0);
    check("pas_src_sel", src_sel_o, 1);
    check("pas_busy", busy_o, 0);
    src_data_i = {32'hDEADBEEF, 32'hAAAA5555}; src_valid_i = 2'b11;
    tick(1); check("pas_word1", bs_data_o, 32'hDEADBEEF);
    check("pas_valid1", bs_valid_o, 1);
    src_data_i = {32'h12345678, 32'h0BADF00D}; src_valid_i = 2'b11;
    tick(1); check("pas_word2", bs_data_o, 32'h12345678);
    check("pas_valid2", bs_valid_o, 1);
    src_data_i = {32'h0, 32'h55AA55AA}; src_valid_i = 2'b01;
    tick(1); check("pas_junk_ignored", bs_valid_o, 0);
    src_valid_i = 2'b00;
    base = n_starts;
    warmboot_req_i = 1'b1; warmboot_slot_i = 4'd11;
    tick(1); warmboot_req_i = 1'b0;
    tick(3); check("pas_no_start", n_starts, base);

    // Back to flash mode; passive edge must not have been queued
    mode_i = 1'b0;
    tick(5); check("idle_src_sel", src_sel_o, 0);
    check("idle_no_queued", n_starts, base);

    // Mode toggle during LOAD, then reset mid-LOAD with a queued edge
    warmboot_req_i = 1'b1; warmboot_slot_i = 4'd4;
    tick(1); check("e_start", ctrl_start_o, 1);
    check("e_slot", ctrl_slot_o, 4);
    check("e_count", boot_count_o, 8);
    warmboot_req_i = 1'b0; ctrl_busy_i = 1'b1;
    src_data_i = {32'h0, 32'hCAFEF00D}; src_valid_i = 2'b01;
    mode_i = 1'b1;
    tick(5); check("load_src_frozen", src_sel_o, 0);
    check("load_data_src0", bs_data_o, 32'hCAFEF00D);
    mode_i = 1'b0;
    tick(2); mode_i = 1'b1;
    tick(3); check("load_src_frozen2", src_sel_o, 0);
    warmboot_req_i = 1'b1; warmboot_slot_i = 4'd6;
    tick(1); warmboot_req_i = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sync", rst_n_sync_o, 0);
    check("mid_rst_slot", ctrl_slot_o, 0);
    check("mid_rst_count", boot_count_o, 0);
    check("mid_rst_data", bs_data_o, 0);
    check("mid_rst_valid", bs_valid_o, 0);
    check("mid_rst_busy", busy_o, 1);
    check("mid_rst_src_sel", src_sel_o, 0);
    mode_i = 1'b0; ctrl_busy_i = 1'b0; src_valid_i = '0; cfg_configured_i = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3); check("re_boot_start", ctrl_start_o, 1);
    check("re_boot_slot", ctrl_slot_o, 0);
    check("re_boot_count", boot_count_o, 1);
    base = n_starts + 1;
    ctrl_busy_i = 1'b1;
    tick(3); ctrl_busy_i = 1'b0;
    tick(5); check("re_queue_cleared", n_starts, base);
    check("re_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
